// File: rtl/hazard_stall_ctrl.sv
// RAW hazard stall / branch flush sequencer for the non-forwarding 5-stage core.
// Optional HAZ_PERF_EN macro adds free-running stall-cycle and flush counters.
module hazard_stall_ctrl #(
  parameter int WRITE_THRU = 1,
  parameter int REG_AW     = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_rs1_addr_id,
  input  logic [REG_AW-1:0] i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [REG_AW-1:0] i_rd_addr_ex,
  input  logic [REG_AW-1:0] i_rd_addr_mem,
  input  logic [REG_AW-1:0] i_rd_addr_wb,
  input  logic              i_rd_wren_ex,
  input  logic              i_rd_wren_mem,
  input  logic              i_rd_wren_wb,
  input  logic              i_pc_sel_ex,
  output logic              o_enable_pc,
  output logic              o_enable_ifid,
  output logic              o_flush_ifid,
  output logic              o_flush_idex,
  output logic              o_stall
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_flush_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hit_ex, hit_mem, hit_wb;
  logic [1:0] n_req;
  logic       stall_now;

  function automatic logic stage_hit(input logic wren, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1, input logic used1,
                                     input logic [REG_AW-1:0] rs2, input logic used2);
    return wren && (rd != '0) && ((used1 && (rs1 == rd)) || (used2 && (rs2 == rd)));
  endfunction

  // Youngest matching stage dictates how long ID must wait for its operand.
  always_comb begin
    hit_ex  = stage_hit(i_rd_wren_ex, i_rd_addr_ex, i_rs1_addr_id, i_rs1_used_id,
                        i_rs2_addr_id, i_rs2_used_id);
    hit_mem = stage_hit(i_rd_wren_mem, i_rd_addr_mem, i_rs1_addr_id, i_rs1_used_id,
                        i_rs2_addr_id, i_rs2_used_id);
    hit_wb  = stage_hit(i_rd_wren_wb, i_rd_addr_wb, i_rs1_addr_id, i_rs1_used_id,
                        i_rs2_addr_id, i_rs2_used_id);
    n_req = 2'd0;
    if (hit_ex)
      n_req = (WRITE_THRU != 0) ? 2'd2 : 2'd3;
    else if (hit_mem)
      n_req = (WRITE_THRU != 0) ? 2'd1 : 2'd2;
    else if (hit_wb)
      n_req = (WRITE_THRU != 0) ? 2'd0 : 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_now = 1'b0;
    if (i_pc_sel_ex) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (n_req != 2'd0) begin
            stall_now = 1'b1;
            if (n_req > 2'd1) begin
              state_d = STALL;
              cnt_d   = n_req - 2'd1;
            end
          end
        end
        STALL: begin
          // Comparators are ignored here: the stall length was fixed on entry.
          stall_now = 1'b1;
          cnt_d     = cnt_q - 2'd1;
          if (cnt_q == 2'd1)
            state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset beats redirect, and redirect beats stall, since it kills the ID instruction.
  always_comb begin
    o_enable_pc   = 1'b1;
    o_enable_ifid = 1'b1;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_stall       = 1'b0;
    if (!i_reset) begin
      o_enable_pc   = 1'b0;
      o_enable_ifid = 1'b0;
      o_flush_ifid  = 1'b1;
      o_flush_idex  = 1'b1;
    end else if (i_pc_sel_ex) begin
      o_flush_ifid = 1'b1;
      o_flush_idex = 1'b1;
    end else if (stall_now) begin
      o_enable_pc   = 1'b0;
      o_enable_ifid = 1'b0;
      o_flush_idex  = 1'b1;
      o_stall       = 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, o_stall};
    flush_count_d  = flush_count_q + {31'd0, i_pc_sel_ex};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: one write-through and one
// non-write-through instance share stimulus and are checked against a stall-budget model.
module tb_hazard_stall_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rdEx = '0, rdMem = '0, rdWb = '0;
  logic          used1 = 1'b0, used2 = 1'b0, wrEx = 1'b0, wrMem = 1'b0, wrWb = 1'b0;
  logic          pcSel = 1'b0;

  logic wtEnPc, wtEnIfid, wtFlIfid, wtFlIdex, wtStall;
  logic nwEnPc, nwEnIfid, nwFlIfid, nwFlIdex, nwStall;
  logic [4:0] wtOut, nwOut;

`ifdef HAZ_PERF_EN
  logic [31:0] wtStallCycles, wtFlushCount, nwStallCycles, nwFlushCount;
`endif

  int checks   = 0;
  int failures = 0;
  int remWt    = 0;
  int remNw    = 0;

  always #5 clk = ~clk;

  assign wtOut = {wtEnPc, wtEnIfid, wtFlIfid, wtFlIdex, wtStall};
  assign nwOut = {nwEnPc, nwEnIfid, nwFlIfid, nwFlIdex, nwStall};

  hazard_stall_ctrl #(.WRITE_THRU(1), .REG_AW(AW)) dutWt (
    .i_clk(clk), .i_reset(rstN),
    .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
    .i_rs1_used_id(used1), .i_rs2_used_id(used2),
    .i_rd_addr_ex(rdEx), .i_rd_addr_mem(rdMem), .i_rd_addr_wb(rdWb),
    .i_rd_wren_ex(wrEx), .i_rd_wren_mem(wrMem), .i_rd_wren_wb(wrWb),
    .i_pc_sel_ex(pcSel),
    .o_enable_pc(wtEnPc), .o_enable_ifid(wtEnIfid),
    .o_flush_ifid(wtFlIfid), .o_flush_idex(wtFlIdex), .o_stall(wtStall)
`ifdef HAZ_PERF_EN
    , .o_stall_cycles(wtStallCycles), .o_flush_count(wtFlushCount)
`endif
  );

  hazard_stall_ctrl #(.WRITE_THRU(0), .REG_AW(AW)) dutNw (
    .i_clk(clk), .i_reset(rstN),
    .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
    .i_rs1_used_id(used1), .i_rs2_used_id(used2),
    .i_rd_addr_ex(rdEx), .i_rd_addr_mem(rdMem), .i_rd_addr_wb(rdWb),
    .i_rd_wren_ex(wrEx), .i_rd_wren_mem(wrMem), .i_rd_wren_wb(wrWb),
    .i_pc_sel_ex(pcSel),
    .o_enable_pc(nwEnPc), .o_enable_ifid(nwEnIfid),
    .o_flush_ifid(nwFlIfid), .o_flush_idex(nwFlIdex), .o_stall(nwStall)
`ifdef HAZ_PERF_EN
    , .o_stall_cycles(nwStallCycles), .o_flush_count(nwFlushCount)
`endif
  );

  // Output vectors are {enable_pc, enable_ifid, flush_ifid, flush_idex, stall}.
  localparam logic [4:0] OUT_RESET  = 5'b00110;
  localparam logic [4:0] OUT_REDIR  = 5'b11110;
  localparam logic [4:0] OUT_STALL  = 5'b00011;
  localparam logic [4:0] OUT_NORMAL = 5'b11000;

  function automatic bit stageHit(input logic wren, input logic [AW-1:0] rd);
    return wren && (rd != 0) && ((used1 && rs1 == rd) || (used2 && rs2 == rd));
  endfunction

  // Cycles the ID instruction must wait: an operand produced k stages ahead of WB needs k cycles,
  // plus one more when the regfile cannot forward a same-cycle write to the read.
  function automatic int stallNeed(input bit writeThru);
    int extra = writeThru ? 0 : 1;
    int n = 0;
    if (stageHit(wrWb, rdWb)   && extra     > n) n = extra;
    if (stageHit(wrMem, rdMem) && extra + 1 > n) n = extra + 1;
    if (stageHit(wrEx, rdEx)   && extra + 2 > n) n = extra + 2;
    return n;
  endfunction

  function automatic logic [4:0] expOut(input int rem, input bit writeThru);
    if (!rstN) return OUT_RESET;
    if (pcSel) return OUT_REDIR;
    if (rem > 0 || stallNeed(writeThru) > 0) return OUT_STALL;
    return OUT_NORMAL;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      remWt <= 0;
      remNw <= 0;
    end else if (pcSel) begin
      remWt <= 0;
      remNw <= 0;
    end else begin
      remWt <= (remWt > 0) ? remWt - 1 : ((stallNeed(1) > 0) ? stallNeed(1) - 1 : 0);
      remNw <= (remNw > 0) ? remNw - 1 : ((stallNeed(0) > 0) ? stallNeed(0) - 1 : 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_wt", {27'd0, wtOut}, {27'd0, expOut(remWt, 1'b1)});
    checkOutput("model_nw", {27'd0, nwOut}, {27'd0, expOut(remNw, 1'b0)});
  end

  // One cycle: drive inputs just after the rising edge, then return at the falling edge.
  task automatic applyStimulus(input logic rst, input int r1, input logic u1,
                               input int r2, input logic u2,
                               input int dEx, input logic wEx, input int dMem, input logic wMem,
                               input int dWb, input logic wWb, input logic sel);
    @(posedge clk);
    #1;
    rstN  = rst;
    rs1   = AW'(r1);   used1 = u1;
    rs2   = AW'(r2);   used2 = u2;
    rdEx  = AW'(dEx);  wrEx  = wEx;
    rdMem = AW'(dMem); wrMem = wMem;
    rdWb  = AW'(dWb);  wrWb  = wWb;
    pcSel = sel;
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string name, input logic [4:0] wtExp, input logic [4:0] nwExp);
    checkOutput({name, "_wt"}, {27'd0, wtOut}, {27'd0, wtExp});
    checkOutput({name, "_nw"}, {27'd0, nwOut}, {27'd0, nwExp});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) idle(1'b0);
    lit("reset_hold", OUT_RESET, OUT_RESET);
    for (int i = 0; i < 3; i++) idle(1'b1);
    lit("after_release", OUT_NORMAL, OUT_NORMAL);

    // EX match on rs1=5: 2 stall cycles write-through, 3 without.
    applyStimulus(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    lit("ex_c1", OUT_STALL, OUT_STALL);
    idle(1'b1); lit("ex_c2", OUT_STALL, OUT_STALL);
    idle(1'b1); lit("ex_c3", OUT_NORMAL, OUT_STALL);
    idle(1'b1); lit("ex_c4", OUT_NORMAL, OUT_NORMAL);

    // rs2=7 matches MEM and WB: MEM dominates (1 / 2 cycles).
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 7, 1, 7, 1, 0);
    lit("memwb_c1", OUT_STALL, OUT_STALL);
    idle(1'b1); lit("memwb_c2", OUT_NORMAL, OUT_STALL);
    idle(1'b1); lit("memwb_c3", OUT_NORMAL, OUT_NORMAL);

    // x0 and disabled writers are never sources.
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    lit("x0", OUT_NORMAL, OUT_NORMAL);
    applyStimulus(1, 3, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    lit("wren0", OUT_NORMAL, OUT_NORMAL);
    // WB match stalls only when writes are not visible in the same cycle.
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0, 4, 1, 0);
    lit("wb_c1", OUT_NORMAL, OUT_STALL);
    idle(1'b1); lit("wb_c2", OUT_NORMAL, OUT_NORMAL);

    // Redirect on the second stall cycle kills the stall.
    applyStimulus(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    lit("redir_c1", OUT_STALL, OUT_STALL);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lit("redir_c2", OUT_REDIR, OUT_REDIR);
    idle(1'b1); lit("redir_c3", OUT_NORMAL, OUT_NORMAL);

    // Async reset while the non-write-through instance is mid-stall with cnt=2.
    applyStimulus(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    idle(1'b1); lit("async_pre", OUT_STALL, OUT_STALL);
    #2 rstN = 1'b0;
    #1 lit("async_now", OUT_RESET, OUT_RESET);
    idle(1'b0);
    idle(1'b1); lit("async_after", OUT_NORMAL, OUT_NORMAL);
    idle(1'b1); lit("async_after2", OUT_NORMAL, OUT_NORMAL);

    // Small address space forces frequent collisions across all stages.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(7, 0) == 0));
    end

`ifdef HAZ_PERF_EN
    idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) idle(1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1'b1);
    end
    checkOutput("perf_stall_cycles", wtStallCycles, 32'd4);
    checkOutput("perf_flush_count", wtFlushCount, 32'd3);
`endif

    idle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
